// File: rtl/pc_ctrl_pkg.sv
// Purpose: shared types and constants for the instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] JALR_MASK            = 32'hFFFF_FFFE;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_target_sel.sv
// Purpose: selects the redirect target (branch/jal sum or jalr sum with bit 0 cleared) and flags misalignment.
// Latency: purely combinational.
// Backpressure: none.
module pc_target_sel
  import pc_ctrl_pkg::*;
(
  input  logic        is_jalr,
  input  logic [31:0] target,
  input  logic [31:0] rs1_imm,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // jalr drops bit 0 of rs1+imm; bit 1 set means not word aligned
  always_comb begin
    next_pc    = is_jalr ? (rs1_imm & JALR_MASK) : target;
    misaligned = next_pc[1];
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Purpose: owns the PC, issues one imem request at a time, hands instructions to decode, applies redirects (optional PC_MISALIGN_CHECK_EN).
// Latency: zero-wait memory gives req at +1, rvalid at +2, instr_valid at +3; redirect reaches imem_addr next cycle.
// Backpressure: instr_ready low holds the instruction in HOLD and no new request is issued until the handshake.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic        redirect_is_jalr,
  input  logic [31:0] redirect_target,
  input  logic [31:0] redirect_rs1_imm,
  input  logic        halt
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err,
  output logic [31:0] misalign_pc
`endif
);

`ifdef PC_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic         lock_q, lock_d;
  logic         req_q;
  logic         load_instr;
  logic         clr_valid;
  logic [31:0]  sel_pc;
  logic         sel_misaligned;
  logic         bad_redir;

  pc_target_sel u_target_sel (
    .is_jalr    (redirect_is_jalr),
    .target     (redirect_target),
    .rs1_imm    (redirect_rs1_imm),
    .next_pc    (sel_pc),
    .misaligned (sel_misaligned)
  );

  assign bad_redir = redirect_valid & sel_misaligned & MISALIGN_EN;

  // Next-state, PC and kill logic; redirect overrides sequential advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    lock_d     = lock_q;
    load_instr = 1'b0;
    clr_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        // a stale response from a grant abandoned by a misaligned redirect
        if (imem_rvalid && kill_q) kill_d = 1'b0;
        if (!halt && !lock_q) state_d = REQ;
      end
      REQ: begin
        if (imem_rvalid && kill_q) kill_d = 1'b0;
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            load_instr = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          clr_valid = 1'b1;
          pc_d      = pc_q + INSTR_BYTES;
          state_d   = halt ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      if (bad_redir) begin
        // misaligned: keep pc, park in IDLE until a good redirect arrives
        lock_d  = 1'b1;
        pc_d    = pc_q;
        state_d = IDLE;
      end else begin
        lock_d = 1'b0;
        pc_d   = sel_pc;
      end
      case (state_q)
        IDLE: if (!bad_redir) state_d = halt ? IDLE : REQ;
        REQ:  if (imem_gnt) kill_d = 1'b1;
        WAIT: if (!imem_rvalid) kill_d = 1'b1;
        HOLD: begin
          clr_valid = 1'b1;
          if (!bad_redir) state_d = REQ;
        end
        default: ;
      endcase
    end
  end

  // Control state registers; imem_req is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      kill_q  <= 1'b0;
      lock_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      lock_q  <= lock_d;
      req_q   <= (state_d == REQ);
    end
  end

  // Instruction output register towards decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid   <= 1'b0;
      instr         <= '0;
      instr_pc      <= '0;
      instr_pcplus4 <= '0;
    end else if (load_instr) begin
      instr_valid   <= 1'b1;
      instr         <= imem_rdata;
      instr_pc      <= pc_q;
      instr_pcplus4 <= pc_q + INSTR_BYTES;
    end else if (clr_valid) begin
      instr_valid   <= 1'b0;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // One-cycle misalignment pulse with the offending target captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      misalign_pc  <= '0;
    end else begin
      misalign_err <= bad_redir;
      if (bad_redir) misalign_pc <= sel_pc;
    end
  end
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Purpose: directed vector bench for pc_fetch_ctrl with hand-computed expectations.
// Latency: each vector row is one clock cycle; outputs checked at the falling edge.
// Backpressure: instr_ready and imem_gnt are driven per row.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        instr_ready;
  logic        redirect_valid;
  logic        redirect_is_jalr;
  logic [31:0] redirect_target;
  logic [31:0] redirect_rs1_imm;
  logic        halt;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_err;
  logic [31:0] misalign_pc;
`endif

  int errs   = 0;
  int checks = 0;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_pcplus4    (instr_pcplus4),
    .instr_ready      (instr_ready),
    .redirect_valid   (redirect_valid),
    .redirect_is_jalr (redirect_is_jalr),
    .redirect_target  (redirect_target),
    .redirect_rs1_imm (redirect_rs1_imm),
    .halt             (halt)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign_err     (misalign_err),
    .misalign_pc      (misalign_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        rd;
    logic        jalr;
    logic [31:0] tgt;
    logic [31:0] rs1;
    logic        hlt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic g, logic rv, logic [31:0] rdat, logic rdy, logic rd,
                              logic j, logic [31:0] t, logic [31:0] r1, logic h,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v = '{g, rv, rdat, rdy, rd, j, t, r1, h, er, ea, ev, ei, ep};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imem_gnt         = v.gnt;
    imem_rvalid      = v.rv;
    imem_rdata       = v.rdata;
    instr_ready      = v.rdy;
    redirect_valid   = v.rd;
    redirect_is_jalr = v.jalr;
    redirect_target  = v.tgt;
    redirect_rs1_imm = v.rs1;
    halt             = v.hlt;
  endtask

  task automatic idle_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; instr_ready = 0;
    redirect_valid = 0; redirect_is_jalr = 0; redirect_target = '0;
    redirect_rs1_imm = '0; halt = 0;
  endtask

  initial begin
    logic [31:0] exp_p4;

    // g rv rdata rdy rd j tgt rs1 h | req addr vld instr pc
    add(0,0,32'h0,0,0,0,32'h0,32'h0,0,           0,32'h0,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h0,0,32'h0,32'h0);
    add(0,1,32'hA000_0013,0,0,0,32'h0,32'h0,0,   0,32'h0,0,32'h0,32'h0);
    add(0,0,32'h0,1,0,0,32'h0,32'h0,0,           0,32'h0,1,32'hA000_0013,32'h0);
    add(1,0,32'h0,1,0,0,32'h0,32'h0,0,           1,32'h4,0,32'h0,32'h0);
    add(0,1,32'hB000_0013,0,0,0,32'h0,32'h0,0,   0,32'h4,0,32'h0,32'h0);
    add(0,0,32'h0,1,0,0,32'h0,32'h0,0,           0,32'h4,1,32'hB000_0013,32'h4);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h8,0,32'h0,32'h0);
    add(0,1,32'hC000_0013,0,0,0,32'h0,32'h0,0,   0,32'h8,0,32'h0,32'h0);
    for (int k = 0; k < 5; k++)
      add(0,0,32'h0,0,0,0,32'h0,32'h0,0,         0,32'h8,1,32'hC000_0013,32'h8);
    add(0,0,32'h0,1,0,0,32'h0,32'h0,0,           0,32'h8,1,32'hC000_0013,32'h8);
    add(0,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'hC,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'hC,0,32'h0,32'h0);
    // jalr during WAIT: bit 0 cleared, in-flight response dropped
    add(0,0,32'h0,0,1,1,32'hDEAD_0000,32'h0000_1235,0, 0,32'hC,0,32'h0,32'h0);
    add(0,1,32'h0000_0BAD,0,0,0,32'h0,32'h0,0,   0,32'h1234,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h1234,0,32'h0,32'h0);
    add(0,1,32'hD000_0013,0,0,0,32'h0,32'h0,0,   0,32'h1234,0,32'h0,32'h0);
    // branch redirect in the same cycle as the HOLD handshake
    add(0,0,32'h0,1,1,0,32'h80,32'h0,0,          0,32'h1234,1,32'hD000_0013,32'h1234);
    add(0,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h80,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h80,0,32'h0,32'h0);
    // halt during WAIT: deliver, then idle
    add(0,0,32'h0,0,0,0,32'h0,32'h0,1,           0,32'h80,0,32'h0,32'h0);
    add(0,1,32'hE000_0013,0,0,0,32'h0,32'h0,1,   0,32'h80,0,32'h0,32'h0);
    add(0,0,32'h0,1,0,0,32'h0,32'h0,1,           0,32'h80,1,32'hE000_0013,32'h80);
    // redirect while idle and halted: pc moves, no request
    add(0,0,32'h0,0,1,0,32'h500,32'h0,1,         0,32'h84,0,32'h0,32'h0);
    add(0,0,32'h0,0,0,0,32'h0,32'h0,1,           0,32'h500,0,32'h0,32'h0);
    add(0,0,32'h0,0,0,0,32'h0,32'h0,0,           0,32'h500,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h500,0,32'h0,32'h0);
    // redirect in WAIT with same-cycle rvalid
    add(0,1,32'hF000_0013,0,1,0,32'h200,32'h0,0, 0,32'h500,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h200,0,32'h0,32'h0);
    add(0,1,32'h0000_0011,0,0,0,32'h0,32'h0,0,   0,32'h200,0,32'h0,32'h0);
    // redirect in HOLD without ready: instruction discarded
    add(0,0,32'h0,0,1,0,32'h300,32'h0,0,         0,32'h200,1,32'h0000_0011,32'h200);
    // redirect in REQ with same-cycle grant
    add(1,0,32'h0,0,1,0,32'h400,32'h0,0,         1,32'h300,0,32'h0,32'h0);
    add(0,1,32'h0000_BAD2,0,0,0,32'h0,32'h0,0,   0,32'h400,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h400,0,32'h0,32'h0);
    add(0,1,32'h0000_0022,0,0,0,32'h0,32'h0,0,   0,32'h400,0,32'h0,32'h0);
    add(0,0,32'h0,1,0,0,32'h0,32'h0,0,           0,32'h400,1,32'h0000_0022,32'h400);
    // pc wrap at the top of the address space
    add(0,0,32'h0,0,1,0,32'hFFFF_FFFC,32'h0,0,   1,32'h404,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'hFFFF_FFFC,0,32'h0,32'h0);
    add(0,1,32'h0000_0033,0,0,0,32'h0,32'h0,0,   0,32'hFFFF_FFFC,0,32'h0,32'h0);
    add(0,0,32'h0,1,0,0,32'h0,32'h0,0,           0,32'hFFFF_FFFC,1,32'h0000_0033,32'hFFFF_FFFC);
    add(1,0,32'h0,0,0,0,32'h0,32'h0,0,           1,32'h0,0,32'h0,32'h0);

    // reset state
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst imem_req", {31'd0, imem_req}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst instr_valid", {31'd0, instr_valid}, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst instr_pcplus4", instr_pcplus4, 32'h0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vq[i].e_req});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vq[i].e_vld});
      if (vq[i].e_vld) begin
        exp_p4 = vq[i].e_pc + 32'd4;
        chk($sformatf("v%0d instr", i), instr, vq[i].e_instr);
        chk($sformatf("v%0d instr_pc", i), instr_pc, vq[i].e_pc);
        chk($sformatf("v%0d instr_pcplus4", i), instr_pcplus4, exp_p4);
      end
      drive(vq[i]);
      @(negedge clk);
    end

    // asynchronous reset while a grant is outstanding
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("arst imem_req", {31'd0, imem_req}, 32'h0);
    chk("arst imem_addr", imem_addr, 32'h0);
    chk("arst instr_valid", {31'd0, instr_valid}, 32'h0);
    chk("arst instr", instr, 32'h0);
    chk("arst instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0044;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late rvalid instr_valid", {31'd0, instr_valid}, 32'h0);
    chk("late rvalid imem_req", {31'd0, imem_req}, 32'h1);
    @(negedge clk);
    chk("late rvalid instr_valid2", {31'd0, instr_valid}, 32'h0);

    // redirect to a target with bit 1 set while requesting
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    @(negedge clk);
    redirect_valid  = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    chk("mis err pulse", {31'd0, misalign_err}, 32'h1);
    chk("mis pc", misalign_pc, 32'h0000_0102);
    chk("mis imem_req", {31'd0, imem_req}, 32'h0);
    chk("mis pc unchanged", imem_addr, 32'h0);
    @(negedge clk);
    chk("mis err cleared", {31'd0, misalign_err}, 32'h0);
    repeat (2) @(negedge clk);
    chk("mis stays idle", {31'd0, imem_req}, 32'h0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    @(negedge clk);
    redirect_valid  = 1'b0;
    @(negedge clk);
    chk("mis resume req", {31'd0, imem_req}, 32'h1);
    chk("mis resume addr", imem_addr, 32'h0000_0040);
`else
    chk("unaligned target req", {31'd0, imem_req}, 32'h1);
    chk("unaligned target addr", imem_addr, 32'h0000_0102);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
